// File: rtl/bcd_display_pkg.sv
// Shared types and constants for the two-digit multiplexed seven-segment driver.
package bcd_display_pkg;

  // Scan slots in the order they are visited.
  typedef enum logic [1:0] {
    ST_GAP1 = 2'd0,
    ST_ONES = 2'd1,
    ST_GAP0 = 2'd2,
    ST_TENS = 2'd3
  } scan_state_t;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_BLANK  = 7'h7F;
  localparam logic [6:0] SEG_DASH   = 7'h3F;

  // Active-low anode patterns; bit 0 is the ones digit, bit 1 the tens digit.
  localparam logic [1:0] ANODE_OFF  = 2'b11;
  localparam logic [1:0] ANODE_ONES = 2'b10;
  localparam logic [1:0] ANODE_TENS = 2'b01;

  // Digit pattern ROM; anything outside 0..9 shows a dash.
  function automatic logic [6:0] digit_pattern(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'h40;
      4'd1:    p = 7'h79;
      4'd2:    p = 7'h24;
      4'd3:    p = 7'h30;
      4'd4:    p = 7'h19;
      4'd5:    p = 7'h12;
      4'd6:    p = 7'h02;
      4'd7:    p = 7'h78;
      4'd8:    p = 7'h00;
      4'd9:    p = 7'h10;
      default: p = SEG_DASH;
    endcase
    return p;
  endfunction

  // Successor slot in the scan ring.
  function automatic scan_state_t next_state(input scan_state_t s);
    scan_state_t n;
    case (s)
      ST_GAP1: n = ST_ONES;
      ST_ONES: n = ST_GAP0;
      ST_GAP0: n = ST_TENS;
      ST_TENS: n = ST_GAP1;
      default: n = ST_GAP1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low seven-segment decoder (dash for codes above 9).
module bcd_to_7seg
  import bcd_display_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  // Pure table lookup; the ROM default supplies the dash for non-BCD codes.
  always_comb begin
    o_seg = digit_pattern(i_bcd);
  end

endmodule

// File: rtl/bcd_display_scan.sv
// Two-digit time-multiplexed common-anode display driver with frame-consistent
// input capture, leading-zero blanking, invalid-digit flag and blink on carry.
module bcd_display_scan
  import bcd_display_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int GAP_CYCLES   = 16,
  parameter int BLINK_FRAMES = 25
) (
  input  logic       clk,
  input  logic       n_clr,
  input  logic [3:0] q1,
  input  logic [3:0] q2,
  input  logic       co,
  input  logic       blank_lz,
  output logic [6:0] seg,
  output logic       dp,
  output logic [1:0] an,
  output logic       err
);

  localparam int CNT_MAX = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int FW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST     = CW'(GAP_CYCLES - 1);
  localparam logic [FW-1:0] FRAME_LAST   = FW'(BLINK_FRAMES - 1);

  scan_state_t   r_state;
  logic [CW-1:0] r_cnt;
  logic [FW-1:0] r_frame;
  logic          r_blink_phase;
  logic          r_blink_hold;
  logic [3:0]    r_h1;
  logic [3:0]    r_h2;
  logic          r_hco;
  logic          r_blz;
  logic          r_err;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic [1:0]    r_an;

  logic          w_slot_done;
  logic          w_capture;
  logic [3:0]    w_dec_in;
  logic [6:0]    w_dec_seg;
  logic [6:0]    w_seg_nx;
  logic          w_dp_nx;
  logic [1:0]    w_an_nx;

  // Detect the last cycle of the current slot; lit slots and gaps differ in length.
  always_comb begin
    w_slot_done = 1'b0;
    case (r_state)
      ST_ONES, ST_TENS: w_slot_done = (r_cnt == REFRESH_LAST);
      ST_GAP0, ST_GAP1: w_slot_done = (r_cnt == GAP_LAST);
      default:          w_slot_done = 1'b1;
    endcase
  end

  assign w_capture = (r_state == ST_GAP1) && w_slot_done;

  // Scan FSM: advance around the slot ring, slot counter restarts on every change.
  always_ff @(posedge clk or negedge n_clr) begin
    if (!n_clr) begin
      r_state <= ST_GAP1;
      r_cnt   <= '0;
    end else if (w_slot_done) begin
      r_state <= next_state(r_state);
      r_cnt   <= '0;
    end else begin
      r_cnt   <= r_cnt + CW'(1);
    end
  end

  // Latch one consistent frame of inputs and advance the blink cadence at capture.
  // The blink phase is held with the frame so a toggle never splits a frame.
  always_ff @(posedge clk or negedge n_clr) begin
    if (!n_clr) begin
      r_h1          <= 4'd0;
      r_h2          <= 4'd0;
      r_hco         <= 1'b0;
      r_blz         <= 1'b0;
      r_err         <= 1'b0;
      r_frame       <= '0;
      r_blink_phase <= 1'b0;
      r_blink_hold  <= 1'b0;
    end else if (w_capture) begin
      r_h1         <= q1;
      r_h2         <= q2;
      r_hco        <= co;
      r_blz        <= blank_lz;
      r_err        <= (q1 > 4'd9) || (q2 > 4'd9);
      r_blink_hold <= r_blink_phase;
      if (r_frame == FRAME_LAST) begin
        r_frame       <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_frame       <= r_frame + FW'(1);
      end
    end
  end

  // A single decoder is shared; it sees the tens digit only during the tens slot.
  assign w_dec_in = (r_state == ST_TENS) ? r_h2 : r_h1;

  bcd_to_7seg u_dec (
    .i_bcd (w_dec_in),
    .o_seg (w_dec_seg)
  );

  // Next display values, highest-priority blanking condition first.
  always_comb begin
    w_an_nx  = ANODE_OFF;
    w_seg_nx = SEG_BLANK;
    w_dp_nx  = 1'b1;
    if ((r_state == ST_GAP0) || (r_state == ST_GAP1)) begin
      w_an_nx  = ANODE_OFF;
      w_seg_nx = SEG_BLANK;
      w_dp_nx  = 1'b1;
    end else if (r_hco && r_blink_hold) begin
      w_an_nx  = ANODE_OFF;
      w_seg_nx = SEG_BLANK;
      w_dp_nx  = 1'b1;
    end else if (r_state == ST_ONES) begin
      w_an_nx  = ANODE_ONES;
      w_seg_nx = w_dec_seg;
      w_dp_nx  = ~r_hco;
    end else if (r_blz && (r_h2 == 4'd0)) begin
      w_an_nx  = ANODE_OFF;
      w_seg_nx = SEG_BLANK;
      w_dp_nx  = 1'b1;
    end else begin
      w_an_nx  = ANODE_TENS;
      w_seg_nx = w_dec_seg;
      w_dp_nx  = 1'b1;
    end
  end

  // Register the display outputs; reset forces the display dark immediately.
  always_ff @(posedge clk or negedge n_clr) begin
    if (!n_clr) begin
      r_an  <= ANODE_OFF;
      r_seg <= SEG_BLANK;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= w_an_nx;
      r_seg <= w_seg_nx;
      r_dp  <= w_dp_nx;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;
  assign err = r_err;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Self-checking bench for bcd_display_scan: time-based behavioural model plus
// directed literal expectations and randomized input/reset stimulus.
module tb_bcd_display_scan;

  localparam int R  = 4;
  localparam int G  = 1;
  localparam int BF = 2;
  localparam int FRAME_LEN = 2 * (R + G);

  logic       clk;
  logic       n_clr;
  logic [3:0] q1;
  logic [3:0] q2;
  logic       co;
  logic       blank_lz;
  logic [6:0] seg;
  logic       dp;
  logic [1:0] an;
  logic       err;

  int n_checks;
  int n_pass;

  // Model state: edges since reset release, captures taken, held frame values.
  int         m_k;
  int         m_frames;
  logic [3:0] m_h1;
  logic [3:0] m_h2;
  logic       m_hco;
  logic       m_blz;
  logic       m_err;
  logic [1:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp;
  logic [6:0] pat [16];

  bcd_display_scan #(
    .REFRESH_DIV  (R),
    .GAP_CYCLES   (G),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk      (clk),
    .n_clr    (n_clr),
    .q1       (q1),
    .q2       (q2),
    .co       (co),
    .blank_lz (blank_lz),
    .seg      (seg),
    .dp       (dp),
    .an       (an),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
  endtask

  // Frame n (0-based) is blanked by the carry blink when floor(n/BF) is odd.
  function automatic bit blink_dark();
    if (m_frames == 0) return 1'b0;
    return (((m_frames - 1) / BF) % 2) == 1;
  endfunction

  // Advance the model by one clock edge, given the inputs present at that edge.
  task automatic model_edge();
    int t;
    t = m_k % FRAME_LEN;
    m_k++;
    e_an  = 2'b11;
    e_seg = 7'h7F;
    e_dp  = 1'b1;
    if (t >= G && t < G + R) begin
      if (!(m_hco && blink_dark())) begin
        e_an  = 2'b10;
        e_seg = pat[m_h1];
        e_dp  = ~m_hco;
      end
    end else if (t >= 2 * G + R) begin
      if (!(m_hco && blink_dark()) && !(m_blz && m_h2 == 4'd0)) begin
        e_an  = 2'b01;
        e_seg = pat[m_h2];
      end
    end
    if (t == G - 1) begin
      m_h1  = q1;
      m_h2  = q2;
      m_hco = co;
      m_blz = blank_lz;
      m_err = (q1 > 4'd9) || (q2 > 4'd9);
      m_frames++;
    end
  endtask

  // One clock: wait for the edge, update the model, compare every output.
  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    check("an",  {30'd0, an},  {30'd0, e_an});
    check("seg", {25'd0, seg}, {25'd0, e_seg});
    check("dp",  {31'd0, dp},  {31'd0, e_dp});
    check("err", {31'd0, err}, {31'd0, m_err});
  endtask

  // Assert reset between edges, verify the immediate dark state, then release.
  task automatic do_reset();
    @(negedge clk);
    n_clr = 1'b0;
    #1;
    check("reset_out", {21'd0, an, seg, dp, err}, {21'd0, 2'b11, 7'h7F, 1'b1, 1'b0});
    m_k = 0; m_frames = 0;
    m_h1 = 4'd0; m_h2 = 4'd0; m_hco = 1'b0; m_blz = 1'b0; m_err = 1'b0;
    @(negedge clk);
    n_clr = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    pat[0] = 7'h40; pat[1] = 7'h79; pat[2] = 7'h24; pat[3] = 7'h30;
    pat[4] = 7'h19; pat[5] = 7'h12; pat[6] = 7'h02; pat[7] = 7'h78;
    pat[8] = 7'h00; pat[9] = 7'h10;
    for (int i = 10; i < 16; i++) pat[i] = 7'h3F;
    n_clr = 1'b0; q1 = 4'd7; q2 = 4'd9; co = 1'b0; blank_lz = 1'b0;
    #2;

    // 97 display, q1 change mid-TENS, then reset during TENS.
    do_reset();
    for (int s = 1; s <= 28; s++) begin
      step();
      if (s == 1)  check("first_dark",  {23'd0, an, seg}, {23'd0, 2'b11, 7'h7F});
      if (s == 2)  check("ones_97",     {23'd0, an, seg}, {23'd0, 2'b10, 7'h78});
      if (s == 5)  check("ones_97_end", {23'd0, an, seg}, {23'd0, 2'b10, 7'h78});
      if (s == 6)  check("gap0_dark",   {23'd0, an, seg}, {23'd0, 2'b11, 7'h7F});
      if (s == 7)  check("tens_97",     {23'd0, an, seg}, {23'd0, 2'b01, 7'h10});
      if (s == 8)  q1 = 4'd8;
      if (s == 9)  check("ones_unchg",  {23'd0, an, seg}, {23'd0, 2'b01, 7'h10});
      if (s == 12) check("ones_98",     {23'd0, an, seg}, {23'd0, 2'b10, 7'h00});
    end
    do_reset();
    for (int s = 1; s <= 3; s++) begin
      step();
      if (s == 1) check("post_rst_dark", {30'd0, an}, {30'd0, 2'b11});
      if (s == 2) check("post_rst_ones", {23'd0, an, seg}, {23'd0, 2'b10, 7'h00});
    end

    // Leading-zero blanking on, then off.
    q2 = 4'd0; q1 = 4'd5; blank_lz = 1'b1;
    do_reset();
    for (int s = 1; s <= 20; s++) begin
      step();
      if (s == 2)  check("ones_05",    {23'd0, an, seg}, {23'd0, 2'b10, 7'h12});
      if (s == 7)  check("tens_blank", {23'd0, an, seg}, {23'd0, 2'b11, 7'h7F});
      if (s == 8)  blank_lz = 1'b0;
      if (s == 17) check("tens_zero",  {23'd0, an, seg}, {23'd0, 2'b01, 7'h40});
    end

    // Blink on carry: frames 0,1 lit, 2,3 dark, 4 lit.
    q2 = 4'd9; q1 = 4'd9; co = 1'b1;
    do_reset();
    for (int s = 1; s <= 50; s++) begin
      step();
      if (s == 2)  check("blink_f0", {29'd0, an, dp}, {29'd0, 2'b10, 1'b0});
      if (s == 12) check("blink_f1", {29'd0, an, dp}, {29'd0, 2'b10, 1'b0});
      if (s == 22) check("blink_f2", {30'd0, an}, {30'd0, 2'b11});
      if (s == 27) check("blink_f2t", {30'd0, an}, {30'd0, 2'b11});
      if (s == 32) check("blink_f3", {30'd0, an}, {30'd0, 2'b11});
      if (s == 42) check("blink_f4", {29'd0, an, dp}, {29'd0, 2'b10, 1'b0});
    end

    // Invalid digit flag and dash, then recovery.
    q2 = 4'd1; q1 = 4'd12; co = 1'b0;
    do_reset();
    for (int s = 1; s <= 14; s++) begin
      step();
      if (s == 1)  check("err_set",   {31'd0, err}, 32'd1);
      if (s == 2)  check("ones_dash", {23'd0, an, seg}, {23'd0, 2'b10, 7'h3F});
      if (s == 5)  q1 = 4'd3;
      if (s == 10) check("err_hold",  {31'd0, err}, 32'd1);
      if (s == 11) check("err_clr",   {31'd0, err}, 32'd0);
      if (s == 12) check("ones_3",    {23'd0, an, seg}, {23'd0, 2'b10, 7'h30});
    end

    // Randomized inputs with occasional mid-frame resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        q1       = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        q2       = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        if ($urandom_range(0, 3) == 0) q2 = 4'd0;
        co       = ($urandom_range(0, 3) == 0);
        blank_lz = ($urandom_range(0, 1) == 1);
      end
      if ($urandom_range(0, 199) == 0) do_reset();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bcd_display_scan.md
# bcd_display_scan

Time-multiplexed two-digit seven-segment driver placed directly downstream of the `bcd_2_digit` counter. It consumes the counter's `q1` (ones), `q2` (tens) and `co` (saturation carry) outputs and produces the shared segment bus and per-digit anode enables for a common-anode display. It includes leading-zero blanking, invalid-BCD flagging and blink-on-carry. All display outputs are registered.

## Interface
- `REFRESH_DIV`, default 50000: clock cycles each digit is lit per slot; must be ≥ 1.
- `GAP_CYCLES`, default 16: all-off ghosting-guard cycles after each digit slot; must be ≥ 1.
- `BLINK_FRAMES`, default 25: frames per blink half-period.
- `clk` in 1: system clock, rising edge.
- `n_clr` in 1: one clock; reset is asynchronous and active-low.
- `q1` in 4: ones digit, BCD.
- `q2` in 4: tens digit, BCD.
- `co` in 1: counter carry/saturation flag.
- `blank_lz` in 1: when 1, a zero tens digit is blanked.
- `seg` out 7: active-low segments, bit order {g,f,e,d,c,b,a}.
- `dp` out 1: active-low decimal point.
- `an` out 2: active-low anodes; `an[0]` drives the ones digit, `an[1]` drives the tens digit.
- `err` out 1: the held frame contains a non-BCD digit.

## Operation
- FSM states, in cycle order: GAP1 → ONES → GAP0 → TENS → GAP1.
- Slot counter `cnt` runs 0..`REFRESH_DIV`-1 in ONES and TENS, and 0..`GAP_CYCLES`-1 in GAP0 and GAP1. It resets to 0 on every state change.
- Capture: on the edge where the FSM moves GAP1→ONES, the hold registers latch `h1`←`q1`, `h2`←`q2`, `hco`←`co` and `err`←(`q1`>9 or `q2`>9). `blank_lz` is latched at the same edge.
  - Inputs are ignored at all other times, so one frame always shows a single consistent value.
- Frame counter: increments at each capture. When it reaches `BLINK_FRAMES` it clears to 0 and `blink_phase` toggles.
- Decode, handled by the sub-module; values are active-low patterns:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10
  - Codes 10–15 show a dash, 3F.
  - Blank is 7F.
- Next-output rules, in priority order:
  - In GAP0 or GAP1: `an`=11, `seg`=7F, `dp`=1.
  - If `hco`=1 and `blink_phase`=1: `an`=11, `seg`=7F, `dp`=1.
  - In ONES: `an`=10, `seg`=dec(`h1`), `dp`=~`hco`.
  - In TENS with latched `blank_lz`=1 and `h2`=0: `an`=11, `seg`=7F, `dp`=1.
  - In TENS otherwise: `an`=01, `seg`=dec(`h2`), `dp`=1.
- While `hco`=0, `blink_phase` keeps running but has no visible effect.

## Timing
- Reset values, applied asynchronously while `n_clr`=0:
  - FSM state GAP1, `cnt`=0, frame counter 0, `blink_phase`=0
  - `h1`=`h2`=0, `hco`=0
  - `an`=11, `seg`=7F, `dp`=1, `err`=0
- After reset release:
  - The FSM spends `GAP_CYCLES` cycles in GAP1, then the first capture occurs.
  - `an`, `seg` and `dp` are registered from state and hold values, so they lag the state by one clock.
  - The first lit ones digit appears `GAP_CYCLES`+1 edges after release.
- Frame length is 2·(`REFRESH_DIV`+`GAP_CYCLES`) cycles.
- Input-to-display latency is at most one frame plus one cycle.
- `err` updates at the capture edge and holds for the entire frame.
- Reset asserted mid-slot blanks the outputs immediately. Scanning restarts from GAP1 with no partial slot.
- Counter widths are $clog2 of the respective terminal count. All counters wrap only through the FSM, never by overflow.

## Structure
- `bcd_display_pkg` holds the state enum, the segment constants (BLANK=7F, DASH=3F, ANODE_OFF=2'b11) and the digit pattern ROM.
- One sub-module, `bcd_to_7seg`: combinational, 4-bit in, 7-bit active-low out, with the dash for codes >9. It is instantiated once, with its input muxed between `h1` and `h2`.
- Expected size is about 150–200 lines of RTL.

## Test plan
All scenarios use `REFRESH_DIV`=4, `GAP_CYCLES`=1, `BLINK_FRAMES`=2, giving a 10-cycle frame.
- Reset during the TENS slot → `an`=11, `seg`=7F, `dp`=1, `err`=0 before the next edge. After release, one dark cycle, then ONES.
- `q2`=9, `q1`=7, `co`=0 → `an`=10 with `seg`=78 for 4 cycles, then 1 cycle of 11/7F, then `an`=01 with `seg`=10 for 4 cycles. Pattern repeats every 10 cycles.
- `q1` changes from 7 to 8 during the TENS slot → the current frame finishes unchanged, and the next ONES slot shows `seg`=00.
- `q2`=0, `q1`=5, `blank_lz`=1 → the TENS slot shows `an`=11. With `blank_lz`=0 the TENS slot shows `an`=01 and `seg`=40.
- `q2`=`q1`=9, `co`=1 → frames 0 and 1 light, with `dp`=0 in the ONES slot. Frames 2 and 3 keep `an`=11 throughout. Frame 4 lights again.
- `q1`=12 → `seg`=3F in the ONES slot and `err`=1 for that frame. After `q1`=3 is captured in the next frame, `err`=0 and `seg`=30.
